// File: rtl/seven_seg_decoder_decimal.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder_decimal
//
// Registered BCD-to-seven-segment decoder. Each rising clock edge loads the
// segment pattern for the digit on A into the Y register, so Y trails A by
// exactly one cycle. Non-decimal codes (10-15) and unknown inputs show a blank
// display. Segment polarity is chosen at elaboration time.
//
// Parameters
//   ACTIVE_LOW : 1 = segment lit when its bit is 0 (common-anode style)
//                0 = segment lit when its bit is 1 (common-cathode style)
//
// Ports
//   clk   : in  1 bit  sole clock, rising-edge active
//   reset : in  1 bit  synchronous active-high reset, forces a blank display
//   A     : in  4 bits unsigned BCD digit to display
//   Y     : out 7 bits registered segment drive, Y[0]=a ... Y[6]=g
// -----------------------------------------------------------------------------
module seven_seg_decoder_decimal #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] A,
   output logic [6:0] Y
);

   // Blank pattern in the selected polarity.
   localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

   // Digit table is kept in active-low form; the active-high variant is its
   // bitwise inverse, which also maps blank 7'h7F onto 7'h00.
   // A plain case with a default means any X/Z bit on A misses every digit
   // item and lands on blank.
   function automatic logic [6:0] decode_digit(input logic [3:0] digit);
      logic [6:0] seg_n;
      seg_n = 7'h7F;
      case (digit)
         4'd0:    seg_n = 7'h40;
         4'd1:    seg_n = 7'h79;
         4'd2:    seg_n = 7'h24;
         4'd3:    seg_n = 7'h30;
         4'd4:    seg_n = 7'h19;
         4'd5:    seg_n = 7'h12;
         4'd6:    seg_n = 7'h02;
         4'd7:    seg_n = 7'h78;
         4'd8:    seg_n = 7'h00;
         4'd9:    seg_n = 7'h10;
         default: seg_n = 7'h7F;
      endcase
      return ACTIVE_LOW ? seg_n : ~seg_n;
   endfunction

   logic [6:0] w_seg;
   logic [6:0] r_y;

   assign w_seg = decode_digit(A);

   // Output register: the only state in the block.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_y <= BLANK;
      end else begin
         r_y <= w_seg;
      end
   end

   assign Y = r_y;

endmodule

// File: tb/tb_seven_seg_decoder_decimal.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_decoder_decimal
//
// Directed bench for seven_seg_decoder_decimal. Two instances share the same
// inputs: one active-low (default) and one active-high. Inputs change on the
// falling edge and outputs are sampled on the falling edge, so every check
// sees the result of exactly one rising edge.
// -----------------------------------------------------------------------------
module tb_seven_seg_decoder_decimal;

   logic       clk;
   logic       reset;
   logic [3:0] A;
   logic [6:0] Y_lo;
   logic [6:0] Y_hi;

   int vectors;
   int miscompares;

   seven_seg_decoder_decimal #(.ACTIVE_LOW(1'b1)) u_dut_lo (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .Y     (Y_lo)
   );

   seven_seg_decoder_decimal #(.ACTIVE_LOW(1'b0)) u_dut_hi (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .Y     (Y_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [6:0] observed,
                      input logic [6:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s observed=7'h%02h expected=7'h%02h", tag, observed, expected);
      end
   endtask

   // Apply inputs at a falling edge, then wait one full cycle so one rising
   // edge has occurred before the next sample point.
   task automatic step(input logic rst_v, input logic [3:0] a_v);
      reset = rst_v;
      A     = a_v;
      @(negedge clk);
   endtask

   logic [6:0] sweep_exp [10];

   initial begin
      vectors     = 0;
      miscompares = 0;
      sweep_exp   = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      reset = 1'b1;
      A     = 4'd8;
      @(negedge clk);

      // Reset held for two edges with A=8: both show blank.
      chk("reset_edge1_lo", Y_lo, 7'h7F);
      chk("reset_edge1_hi", Y_hi, 7'h00);
      step(1'b1, 4'd8);
      chk("reset_edge2_lo", Y_lo, 7'h7F);
      chk("reset_edge2_hi", Y_hi, 7'h00);

      // Release: first edge with reset low loads decode of 8.
      step(1'b0, 4'd8);
      chk("release_8_lo", Y_lo, 7'h00);
      chk("release_8_hi", Y_hi, 7'h7F);

      // Digit sweep 0..9.
      for (int d = 0; d < 10; d++) begin
         step(1'b0, 4'(d));
         chk($sformatf("sweep_%0d_lo", d), Y_lo, sweep_exp[d]);
      end

      // Invalid codes blank, then recover to a digit.
      step(1'b0, 4'd10);
      chk("invalid_10_lo", Y_lo, 7'h7F);
      step(1'b0, 4'd11);
      chk("invalid_11_lo", Y_lo, 7'h7F);
      step(1'b0, 4'd15);
      chk("invalid_15_lo", Y_lo, 7'h7F);
      chk("invalid_15_hi", Y_hi, 7'h00);
      step(1'b0, 4'd2);
      chk("after_invalid_2_lo", Y_lo, 7'h24);

      // Mid-stream reset with A=5 steady.
      step(1'b0, 4'd5);
      chk("steady_5_lo", Y_lo, 7'h12);
      step(1'b1, 4'd5);
      chk("midreset_lo", Y_lo, 7'h7F);
      chk("midreset_hi", Y_hi, 7'h00);
      step(1'b0, 4'd5);
      chk("midrelease_5_lo", Y_lo, 7'h12);

      // Active-high polarity.
      step(1'b0, 4'd1);
      chk("pol_1_hi", Y_hi, 7'h06);
      chk("pol_1_lo", Y_lo, 7'h79);
      step(1'b0, 4'd12);
      chk("pol_12_hi", Y_hi, 7'h00);
      chk("pol_12_lo", Y_lo, 7'h7F);
      step(1'b0, 4'd6);
      chk("pol_6_hi", Y_hi, 7'h7D);

      // Latency: A moves 3 -> 7 between edges; Y holds until next rising edge.
      step(1'b0, 4'd3);
      chk("lat_3_lo", Y_lo, 7'h30);
      @(posedge clk);
      #2;
      A = 4'd7;
      #1;
      chk("lat_hold_lo", Y_lo, 7'h30);
      chk("lat_hold_hi", Y_hi, 7'h4F);
      @(negedge clk);
      chk("lat_hold_neg_lo", Y_lo, 7'h30);
      @(negedge clk);
      chk("lat_7_lo", Y_lo, 7'h78);
      chk("lat_7_hi", Y_hi, 7'h07);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seven_seg_decoder_decimal.md
SEVEN_SEG_DECODER_DECIMAL -- requirements
Module: seven_seg_decoder_decimal

Interface
REQ-001 The block SHALL have one parameter: ACTIVE_LOW, default 1, selecting segment drive polarity (1 = segment lit when bit is 0; 0 = segment lit when bit is 1).
REQ-002 The block SHALL have port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port A, input, 4 bits, unsigned BCD digit to display.
REQ-005 The block SHALL have port Y, output, 7 bits, registered segment drive, bit order Y[0]=a, Y[1]=b, Y[2]=c, Y[3]=d, Y[4]=e, Y[5]=f, Y[6]=g.

Function
REQ-006 Y SHALL be a register; on each rising clk edge with reset low, Y SHALL load the decode of the A value present before that edge (latency exactly 1 cycle).
REQ-007 With ACTIVE_LOW=1, the decode SHALL be: 0->7'h40, 1->7'h79, 2->7'h24, 3->7'h30, 4->7'h19, 5->7'h12, 6->7'h02, 7->7'h78, 8->7'h00, 9->7'h10.
REQ-008 A values 10-15 are not decimal digits; the decode for them SHALL be blank (all segments off: 7'h7F with ACTIVE_LOW=1).
REQ-009 With ACTIVE_LOW=0, every decoded value, including blank, SHALL be the bitwise inverse of the ACTIVE_LOW=1 value (blank = 7'h00).
REQ-010 The decode SHALL be a pure function of A; no history, no other state besides the Y register.
REQ-011 An X/Z on any bit of A SHALL decode as blank.
REQ-012 Y SHALL change only on rising clk edges; no combinational path from A to Y.

Reset
REQ-013 When reset is high at a rising clk edge, Y SHALL load blank (7'h7F with ACTIVE_LOW=1, 7'h00 with ACTIVE_LOW=0), regardless of A.
REQ-014 Reset SHALL take priority over decode; when reset deasserts, the first edge with reset low SHALL load the decode of the current A.
REQ-015 Before the first reset, Y is unspecified; reset SHALL be asserted for at least one clk edge after power-up.

Verification
REQ-016 Reset: hold reset=1 with A=4'd8 for 2 edges -> Y=7'h7F; release reset -> Y=7'h00 after next edge.
REQ-017 Digit sweep: A=0..9, one value per cycle -> Y=7'h40,79,24,30,19,12,02,78,00,10 each appearing one cycle after its A.
REQ-018 Invalid codes: A=4'd10, then 4'd11, then 4'd15 -> Y=7'h7F for each; then A=4'd2 -> Y=7'h24 one cycle later.
REQ-019 Mid-stream reset: A=4'd5 steady, Y=7'h12; assert reset for 1 edge -> Y=7'h7F; deassert -> Y=7'h12 after next edge.
REQ-020 Polarity: with ACTIVE_LOW=0, A=4'd1 -> Y=7'h06; A=4'd12 -> Y=7'h00; reset -> Y=7'h00.
REQ-021 Latency: A changes between edges 3->7 -> Y stays 7'h30 until the next rising edge, then 7'h78.
